multi_dataflow_engine_ctrl: RTL and testbench
=============================================

// Module: multi_dataflow_engine_ctrl
// PURPOSE
// Engine-side sequencer between the HWPE main FSM and the multi_dataflow engine.
// - On a job start, pushes the 32-bit dataflow configuration word to the engine, but only when it
//   differs from the last word applied.
// - Waits a fixed settle time, then enables the datapath.
// - Counts outStream0 beats up to the programmed limit and reports a one-cycle done.
// PARAMETERS
// CNT_WIDTH   32  width of the beat counter and of cnt_limit_i
// CFG_WIDTH   32  width of the configuration word
// CFG_SETTLE  4   cycles after the config handshake before enable; range 0..255
// PORTS
// clk_i          in   1          clock
// rst_ni         in   1          synchronous reset, active-low
// clear_i        in   1          synchronous soft clear (HWPE clear)
// start_i        in   1          job start pulse from main FSM
// config_i       in   CFG_WIDTH  configuration register value
// cnt_limit_i    in   CNT_WIDTH  outStream0 beats per job (already +1 adjusted)
// cfg_o          out  CFG_WIDTH  configuration word to engine
// cfg_valid_o    out  1          configuration valid
// cfg_ready_i    in   1          engine accepts configuration
// enable_o       out  1          engine datapath enable
// out_valid_i    in   1          outStream0 valid (monitor only)
// out_ready_i    in   1          outStream0 ready (monitor only)
// busy_o         out  1          job in progress
// done_o         out  1          one-cycle job-complete pulse
// cnt_o          out  CNT_WIDTH  beats counted in current job
// BEHAVIOUR
// - All state is updated on the rising edge of clk_i.
// - rst_ni=0 at an edge: state IDLE, count 0, cfg_o 0, cfg_applied flag 0, settle counter 0.
// - Output values while in reset: cfg_valid_o, enable_o, busy_o, done_o are all 0.
// - clear_i=1: same effect as reset, on the same edge; it has priority over all other inputs.
// - FSM states: IDLE, CONFIG, SETTLE, RUN, DONE.
// - IDLE: busy_o=0. On start_i, latch config_i and cnt_limit_i and clear cnt_o. Next state:
//   - latched limit==0 -> DONE;
//   - else cfg_applied==0 or latched config != cfg_o -> CONFIG;
//   - else -> RUN.
//   - cfg_o is loaded from the latched config when the FSM enters CONFIG.
// - CONFIG: cfg_valid_o=1. cfg_o is held stable while cfg_valid_o=1.
//   - cfg_valid_o stays high until cfg_ready_i=1 (valid/ready; valid never drops early).
//   - On handshake: set cfg_applied=1 and go to SETTLE, or straight to RUN if CFG_SETTLE==0.
// - SETTLE: counts CFG_SETTLE cycles with enable_o=0, then goes to RUN.
// - RUN: enable_o=1. A beat is out_valid_i & out_ready_i; each beat increments cnt_o.
//   - The beat that makes cnt_o equal the latched limit moves the FSM to DONE.
//   - enable_o drops on the edge that enters DONE, so there is no enable after the last beat.
// - DONE: done_o=1 for exactly one cycle, then IDLE. cnt_o holds its final value until the next start.
// - busy_o=1 in every state except IDLE.
// - Boundary rules:
//   - start_i while busy_o=1 is ignored.
//   - Beats outside RUN are not counted.
//   - The counter never wraps: limit 2^CNT_WIDTH-1 is reached exactly.
//   - A back-to-back start in the cycle right after done (IDLE) is accepted.
//   - Reset or clear in CONFIG drops cfg_valid_o immediately; the next job always reconfigures.
// - Latency from start to enable_o:
//   - 1 cycle when no reconfiguration is needed;
//   - otherwise 1 + handshake wait + CFG_SETTLE + 1 cycles.
// TESTING
// - T1: config 0xA5, limit 8, cfg_ready_i=1, beats every cycle -> one cfg handshake with cfg_o=0xA5,
//   enable_o after 4 settle cycles, exactly 8 beats counted, done_o one cycle, cnt_o=8.
// - T2: second job with the same config 0xA5, limit 3 -> no cfg_valid_o; enable_o the cycle after
//   start; done_o after the 3rd beat.
// - T3: config 0x3C, cfg_ready_i held low for 5 cycles -> cfg_valid_o=1 and cfg_o=0x3C stable
//   for all 5 cycles; enable_o=0 until handshake+4 settle cycles.
// - T4: limit 0 -> busy_o for 1 cycle, done_o the next cycle, no cfg_valid_o and no enable_o.
// - T5: random out_ready_i stalls, limit 16, start pulsed again mid-RUN -> count 16 exact,
//   second start ignored, a single done_o.
// - T6: clear_i during SETTLE, then rst_ni low during RUN -> outputs 0 on the next edge;
//   a following start with an unchanged config still performs the cfg handshake.

Source files
------------

// File: rtl/multi_dataflow_engine_ctrl.sv
// Sequences one engine job: optional config push, settle wait, then counts outStream0 beats to the limit.
// Latency: 1 cycle start->enable with config unchanged; otherwise CONFIG + handshake wait + CFG_SETTLE cycles.
// Backpressure: cfg_valid_o holds with cfg_o stable until cfg_ready_i; a beat counts only when out_valid_i & out_ready_i.
module multi_dataflow_engine_ctrl #(
    parameter int unsigned CNT_WIDTH  = 32,
    parameter int unsigned CFG_WIDTH  = 32,
    parameter int unsigned CFG_SETTLE = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clear_i,
    input  logic                 start_i,
    input  logic [CFG_WIDTH-1:0] config_i,
    input  logic [CNT_WIDTH-1:0] cnt_limit_i,
    output logic [CFG_WIDTH-1:0] cfg_o,
    output logic                 cfg_valid_o,
    input  logic                 cfg_ready_i,
    output logic                 enable_o,
    input  logic                 out_valid_i,
    input  logic                 out_ready_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [CNT_WIDTH-1:0] cnt_o
);

    typedef enum logic [2:0] {IDLE, CONFIG, SETTLE, RUN, DONE} state_t;

    localparam logic [7:0] SETTLE_LAST = 8'(CFG_SETTLE - 1);

    state_t               state_q, state_d;
    logic [CFG_WIDTH-1:0] cfg_q;
    logic [CNT_WIDTH-1:0] lim_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_inc;
    logic                 cfg_applied_q;
    logic [7:0]           settle_q;
    logic                 beat;
    logic                 last_beat;
    logic                 need_cfg;
    logic                 live;

    assign beat      = out_valid_i & out_ready_i;
    // cnt_q < lim_q whenever RUN is active, so the increment cannot wrap
    assign cnt_inc   = cnt_q + CNT_WIDTH'(1);
    assign last_beat = beat && (cnt_inc == lim_q);
    assign need_cfg  = !cfg_applied_q || (config_i != cfg_q);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (cnt_limit_i == '0)
                        state_d = DONE;
                    else if (need_cfg)
                        state_d = CONFIG;
                    else
                        state_d = RUN;
                end
            end
            CONFIG: begin
                if (cfg_ready_i)
                    state_d = (CFG_SETTLE == 0) ? RUN : SETTLE;
            end
            SETTLE: begin
                if (settle_q == SETTLE_LAST)
                    state_d = RUN;
            end
            RUN: begin
                if (last_beat)
                    state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni || clear_i) begin
            state_q       <= IDLE;
            cfg_q         <= '0;
            lim_q         <= '0;
            cnt_q         <= '0;
            cfg_applied_q <= 1'b0;
            settle_q      <= '0;
        end else begin
            state_q  <= state_d;
            settle_q <= (state_q == SETTLE) ? settle_q + 8'd1 : 8'd0;
            if (state_q == IDLE && start_i) begin
                lim_q <= cnt_limit_i;
                cnt_q <= '0;
                // the applied word only becomes trusted again once the engine accepts it
                if (state_d == CONFIG) begin
                    cfg_q         <= config_i;
                    cfg_applied_q <= 1'b0;
                end
            end
            if (state_q == CONFIG && cfg_ready_i)
                cfg_applied_q <= 1'b1;
            if (state_q == RUN && beat)
                cnt_q <= cnt_inc;
        end
    end

    // controls are forced low while reset or clear is asserted, not only after the edge
    assign live        = rst_ni & ~clear_i;
    assign cfg_valid_o = live & (state_q == CONFIG);
    assign enable_o    = live & (state_q == RUN);
    assign busy_o      = live & (state_q != IDLE);
    assign done_o      = live & (state_q == DONE);
    assign cfg_o       = cfg_q;
    assign cnt_o       = cnt_q;

endmodule

// File: tb/tb_multi_dataflow_engine_ctrl.sv
// Directed bench for multi_dataflow_engine_ctrl; a negedge monitor scores config handshakes and job completions.
module tb_multi_dataflow_engine_ctrl;

    logic        clk = 1'b0;
    logic        rst_n, clear, start, cfg_ready, out_valid, out_ready;
    logic [31:0] config_w, limit;
    logic [31:0] cfg_o, cnt_o;
    logic        cfg_valid, enable, busy, done;

    logic        start_s;
    logic [3:0]  limit_s, cnt_s;
    logic [31:0] cfg_s;
    logic        cfg_valid_s, enable_s, busy_s, done_s;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_cfg_q[$];
    logic [31:0] exp_cnt_q[$];

    always #5 clk = ~clk;

    multi_dataflow_engine_ctrl #(.CNT_WIDTH(32), .CFG_WIDTH(32), .CFG_SETTLE(4)) dut (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .start_i(start),
        .config_i(config_w), .cnt_limit_i(limit), .cfg_o(cfg_o), .cfg_valid_o(cfg_valid),
        .cfg_ready_i(cfg_ready), .enable_o(enable), .out_valid_i(out_valid),
        .out_ready_i(out_ready), .busy_o(busy), .done_o(done), .cnt_o(cnt_o)
    );

    // narrow counter, zero settle: exercises exact reach of the maximum limit and CONFIG->RUN
    multi_dataflow_engine_ctrl #(.CNT_WIDTH(4), .CFG_WIDTH(32), .CFG_SETTLE(0)) dut_s (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .start_i(start_s),
        .config_i(config_w), .cnt_limit_i(limit_s), .cfg_o(cfg_s), .cfg_valid_o(cfg_valid_s),
        .cfg_ready_i(cfg_ready), .enable_o(enable_s), .out_valid_i(out_valid),
        .out_ready_i(out_ready), .busy_o(busy_s), .done_o(done_s), .cnt_o(cnt_s)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // walk to the done cycle, check it, then step into IDLE
    task automatic run_to_done(input string tag, input int exp_en);
        int en = 0;
        int n  = 0;
        while (!done && n < 300) begin
            if (enable) en++;
            tick();
            n++;
        end
        check({tag, "_done_seen"}, done, 1);
        if (exp_en >= 0) check({tag, "_enable_cycles"}, en, exp_en);
        check({tag, "_no_enable_at_done"}, enable, 0);
        tick();
        check({tag, "_done_one_cycle"}, done, 0);
        check({tag, "_idle_after"}, busy, 0);
    endtask

    logic        prev_vld = 1'b0, prev_rdy = 1'b0, prev_done = 1'b0;
    logic [31:0] prev_cfg = '0;

    always @(negedge clk) begin
        if (rst_n && !clear) begin
            if (prev_vld && !prev_rdy) begin
                check("cfg_valid_held", cfg_valid, 1);
                check("cfg_word_stable", cfg_o, prev_cfg);
            end
            if (cfg_valid && cfg_ready) begin
                check("cfg_hs_expected", exp_cfg_q.size() > 0, 1);
                if (exp_cfg_q.size() > 0) check("cfg_hs_word", cfg_o, exp_cfg_q.pop_front());
            end
            if (done) begin
                check("done_single_pulse", prev_done, 0);
                check("done_expected", exp_cnt_q.size() > 0, 1);
                if (exp_cnt_q.size() > 0) check("done_count", cnt_o, exp_cnt_q.pop_front());
            end
        end
        prev_vld  = cfg_valid;
        prev_rdy  = cfg_ready;
        prev_cfg  = cfg_o;
        prev_done = done;
    end

    initial begin
        rst_n = 1'b0; clear = 1'b0; start = 1'b0; start_s = 1'b0;
        cfg_ready = 1'b1; out_valid = 1'b1; out_ready = 1'b1;
        config_w = '0; limit = '0; limit_s = '0;
        #1;
        check("rst_busy_async", busy, 0);
        check("rst_cfg_valid_async", cfg_valid, 0);
        tick(); tick();
        check("rst_busy", busy, 0);
        check("rst_enable", enable, 0);
        check("rst_done", done, 0);
        check("rst_cfg_o", cfg_o, 0);
        check("rst_cnt", cnt_o, 0);
        rst_n = 1'b1;
        tick();

        // T1: fresh config, immediate ready, beats every cycle
        config_w = 32'hA5; limit = 8;
        exp_cfg_q.push_back(32'hA5); exp_cnt_q.push_back(8);
        pulse_start();
        check("t1_cfg_valid", cfg_valid, 1);
        check("t1_cfg_o", cfg_o, 32'hA5);
        check("t1_busy", busy, 1);
        tick();
        for (int i = 0; i < 4; i++) begin
            check("t1_settle_no_enable", enable, 0);
            tick();
        end
        check("t1_enable_after_settle", enable, 1);
        run_to_done("t1", 8);
        check("t1_cnt_held", cnt_o, 8);

        // T2: same config, back-to-back start in the cycle after done
        limit = 3;
        exp_cnt_q.push_back(3);
        pulse_start();
        check("t2_enable_next_cycle", enable, 1);
        check("t2_no_cfg_valid", cfg_valid, 0);
        run_to_done("t2", 3);

        // T3: new config with the engine stalling the handshake
        config_w = 32'h3C; limit = 2; cfg_ready = 1'b0;
        exp_cfg_q.push_back(32'h3C); exp_cnt_q.push_back(2);
        pulse_start();
        for (int i = 0; i < 5; i++) begin
            check("t3_cfg_valid_wait", cfg_valid, 1);
            check("t3_cfg_o_wait", cfg_o, 32'h3C);
            check("t3_enable_wait", enable, 0);
            tick();
        end
        cfg_ready = 1'b1;
        check("t3_cfg_valid_at_hs", cfg_valid, 1);
        tick();
        for (int i = 0; i < 4; i++) begin
            check("t3_settle_no_enable", enable, 0);
            tick();
        end
        check("t3_enable", enable, 1);
        run_to_done("t3", 2);

        // T4: zero limit completes without configuring or enabling
        config_w = 32'h77; limit = 0;
        exp_cnt_q.push_back(0);
        pulse_start();
        check("t4_busy", busy, 1);
        check("t4_done", done, 1);
        check("t4_no_cfg_valid", cfg_valid, 0);
        check("t4_no_enable", enable, 0);
        tick();
        check("t4_idle", busy, 0);
        check("t4_done_low", done, 0);

        // T5: random ready stalls, start re-pulsed with another limit mid-run
        config_w = 32'h3C; limit = 16;
        exp_cnt_q.push_back(16);
        pulse_start();
        check("t5_enable", enable, 1);
        for (int i = 0; i < 5; i++) begin
            out_ready = 1'($urandom_range(0, 1));
            tick();
        end
        limit = 5;
        pulse_start();
        check("t5_busy_after_restart", busy, 1);
        begin
            int n = 0;
            while (!done && n < 500) begin
                out_ready = 1'($urandom_range(0, 1));
                tick();
                n++;
            end
            check("t5_done_seen", done, 1);
        end
        check("t5_cnt_exact", cnt_o, 16);
        out_ready = 1'b1;
        tick();
        check("t5_done_low", done, 0);

        // T6: clear in SETTLE, then reset in RUN; both force reconfiguration
        config_w = 32'h55; limit = 10;
        exp_cfg_q.push_back(32'h55);
        pulse_start();
        tick();
        tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("t6_clear_busy", busy, 0);
        check("t6_clear_cfg_o", cfg_o, 0);
        check("t6_clear_enable", enable, 0);
        exp_cfg_q.push_back(32'h55);
        pulse_start();
        check("t6_reconfig_after_clear", cfg_valid, 1);
        repeat (5) tick();
        check("t6_running", enable, 1);
        tick(); tick();
        rst_n = 1'b0;
        tick();
        check("t6_rst_enable", enable, 0);
        check("t6_rst_cnt", cnt_o, 0);
        rst_n = 1'b1;
        check("t6_rst_busy", busy, 0);
        check("t6_rst_cfg_o", cfg_o, 0);
        limit = 2;
        exp_cfg_q.push_back(32'h55); exp_cnt_q.push_back(2);
        pulse_start();
        check("t6_reconfig_after_rst", cfg_valid, 1);
        check("t6_reconfig_word", cfg_o, 32'h55);
        repeat (5) tick();
        run_to_done("t6", 2);

        // T7: 4-bit counter reaches 15 exactly; zero settle goes CONFIG->RUN
        limit_s = 4'hF;
        start_s = 1'b1;
        tick();
        start_s = 1'b0;
        check("t7_cfg_valid", cfg_valid_s, 1);
        check("t7_cfg_word", cfg_s, 32'h55);
        tick();
        check("t7_enable_no_settle", enable_s, 1);
        begin
            int en = 0;
            int n  = 0;
            while (!done_s && n < 100) begin
                if (enable_s) en++;
                tick();
                n++;
            end
            check("t7_done_seen", done_s, 1);
            check("t7_enable_cycles", en, 15);
        end
        check("t7_cnt_max", cnt_s, 4'hF);
        tick();
        check("t7_idle", busy_s, 0);
        check("t7_cnt_held", cnt_s, 4'hF);

        check("cfg_queue_drained", exp_cfg_q.size(), 0);
        check("done_queue_drained", exp_cnt_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
